mdr_mem_ctrl: RTL and testbench

Memory-interface stage sitting beside the datapath bus mux. It captures the address and data from `BusMuxOut` into MAR and MDR, and runs single-word read/write transactions to the memory over a req/ack handshake. It returns read data through `MDR_Data_Out`, which drives the mux's MDR input (select 21). A cycle timeout flags accesses that memory never acknowledges.

---
 rtl/mdr_mem_ctrl.sv | 109 ++++++++++
 tb/tb_mdr_mem_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_mem_ctrl.sv
// MAR/MDR register pair plus a Moore req/ack engine for single-word memory
// reads and writes, with a per-request cycle timeout.
module mdr_mem_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [31:0]       BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       MDR_Data_Out,
    output logic [ADDR_W-1:0] MAR_Data_Out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        WR_REQ,
        DONE
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] mar;
    logic [31:0]       mdr;
    logic [7:0]        cnt;
    logic              err_q;
    logic              err_next;
    logic              in_req;

    assign in_req = (state == RD_REQ) || (state == WR_REQ);

    // Next state; err_next is latched on the way into DONE and replayed there.
    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (Read && Write) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end else if (Read) begin
                    state_next = RD_REQ;
                end else if (Write) begin
                    state_next = WR_REQ;
                end
            end
            RD_REQ, WR_REQ: begin
                if (mem_ack) begin
                    state_next = DONE;
                end else if (cnt == CNT_LAST) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            mar   <= '0;
            mdr   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= err_next;
            // Counter only survives while staying in a request state.
            if (in_req && (state_next == state))
                cnt <= cnt + 8'd1;
            else
                cnt <= '0;
            // Bus loads only in IDLE so address and write data stay frozen.
            if (state == IDLE && MARin)
                mar <= BusMuxOut[ADDR_W-1:0];
            if (state == IDLE && MDRin)
                mdr <= BusMuxOut;
            else if (state == RD_REQ && mem_ack)
                mdr <= mem_rdata;
        end
    end

    assign mem_req      = in_req;
    assign mem_we       = (state == WR_REQ);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign err          = (state == DONE) && err_q;
    assign mem_addr     = mar;
    assign mem_wdata    = mdr;
    assign MDR_Data_Out = mdr;
    assign MAR_Data_Out = mar;

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Directed self-checking bench for mdr_mem_ctrl: reset, bus loads, read,
// write, timeout, illegal command, mid-transaction reset and back-to-back.
module tb_mdr_mem_ctrl;

    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              clr;
    logic [31:0]       BusMuxOut;
    logic              MARin, MDRin, Read, Write;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_req, mem_we;
    logic [31:0]       MDR_Data_Out;
    logic [ADDR_W-1:0] MAR_Data_Out;
    logic              busy, done, err;

    int errors = 0;
    int checks = 0;

    mdr_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .clr(clr), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
        .Read(Read), .Write(Write), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
        .MDR_Data_Out(MDR_Data_Out), .MAR_Data_Out(MAR_Data_Out),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            BusMuxOut = $urandom;
            MARin     = 1'($urandom);
            MDRin     = 1'($urandom);
            Read      = 1'($urandom);
            Write     = 1'($urandom);
            mem_rdata = $urandom;
            mem_ack   = 1'($urandom);
            step();
        end
        checks++;
        if ({mem_req, mem_we, busy, done, err} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, busy, done, err});
        end
        checks++;
        if (MDR_Data_Out !== 32'h0 || MAR_Data_Out !== 9'h0) begin
            errors++;
            $display("[TB] FAIL reset_regs: got mdr=%h mar=%h expected 0/0", MDR_Data_Out, MAR_Data_Out);
        end
        clr = 1'b0; BusMuxOut = '0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
        mem_rdata = '0; mem_ack = 0;
        step();
    endtask

    task automatic test_bus_loads();
        BusMuxOut = 32'h0000_01A5; MARin = 1'b1;
        step();
        MARin = 1'b0; BusMuxOut = 32'hDEAD_BEEF; MDRin = 1'b1;
        step();
        MDRin = 1'b0; BusMuxOut = '0;
        checks++;
        if (mem_addr !== 9'h1A5 || MAR_Data_Out !== 9'h1A5) begin
            errors++;
            $display("[TB] FAIL mar_load: got %h expected 1a5", mem_addr);
        end
        checks++;
        if (MDR_Data_Out !== 32'hDEAD_BEEF || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL mdr_load: got %h expected deadbeef", MDR_Data_Out);
        end
    endtask

    task automatic test_read_delayed();
        BusMuxOut = 32'h0000_0010; MARin = 1'b1;
        step();
        MARin = 1'b0; BusMuxOut = '0; Read = 1'b1;
        step();
        Read = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 9'h010) begin
                errors++;
                $display("[TB] FAIL read_req_c%0d: got req=%b we=%b addr=%h expected 1/0/010",
                         i, mem_req, mem_we, mem_addr);
            end
            if (i == 3) begin
                mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
            end
            step();
        end
        mem_ack = 1'b0; mem_rdata = '0;
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || mem_req !== 1'b0 || MDR_Data_Out !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL read_done: got done=%b err=%b req=%b mdr=%h expected 1/0/0/12345678",
                     done, err, mem_req, MDR_Data_Out);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_idle: got done=%b busy=%b expected 0/0", done, busy);
        end
    endtask

    task automatic test_write_frozen();
        BusMuxOut = 32'hCAFE_0001; MDRin = 1'b1;
        step();
        MDRin = 1'b0; Write = 1'b1;
        step();
        Write = 1'b0; MDRin = 1'b1; BusMuxOut = '0; mem_ack = 1'b1;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hCAFE_0001) begin
            errors++;
            $display("[TB] FAIL write_req: got req=%b we=%b wdata=%h expected 1/1/cafe0001",
                     mem_req, mem_we, mem_wdata);
        end
        step();
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || mem_wdata !== 32'hCAFE_0001) begin
            errors++;
            $display("[TB] FAIL write_done: got done=%b err=%b wdata=%h expected 1/0/cafe0001",
                     done, err, mem_wdata);
        end
        MDRin = 1'b0; mem_ack = 1'b0;
        step();
        checks++;
        if (MDR_Data_Out !== 32'hCAFE_0001 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_after: got mdr=%h done=%b expected cafe0001/0", MDR_Data_Out, done);
        end
    endtask

    task automatic test_timeout();
        int n;
        Read = 1'b1;
        step();
        Read = 1'b0;
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        checks++;
        if (n !== TIMEOUT) begin
            errors++;
            $display("[TB] FAIL timeout_len: got %0d req cycles expected %0d", n, TIMEOUT);
        end
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || MDR_Data_Out !== 32'hCAFE_0001) begin
            errors++;
            $display("[TB] FAIL timeout_done: got done=%b err=%b mdr=%h expected 1/1/cafe0001",
                     done, err, MDR_Data_Out);
        end
        step();
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_idle: got done=%b err=%b busy=%b expected 0/0/0", done, err, busy);
        end
    endtask

    task automatic test_illegal();
        Read = 1'b1; Write = 1'b1;
        step();
        Read = 1'b0; Write = 1'b0;
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL illegal_cmd: got done=%b err=%b req=%b busy=%b expected 1/1/0/1",
                     done, err, mem_req, busy);
        end
        step();
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_idle: got busy=%b req=%b expected 0/0", busy, mem_req);
        end
    endtask

    task automatic test_mid_reset();
        Read = 1'b1;
        step();
        Read = 1'b0;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_req: got %b expected 1", mem_req);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || MDR_Data_Out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midrst_after: got req=%b busy=%b mdr=%h expected 0/0/0",
                     mem_req, busy, MDR_Data_Out);
        end
    endtask

    task automatic test_back_to_back();
        BusMuxOut = 32'h0000_00AB; MARin = 1'b1; Read = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        step();
        MARin = 1'b0; BusMuxOut = '0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 9'h0AB) begin
            errors++;
            $display("[TB] FAIL b2b_req1: got req=%b addr=%h expected 1/0ab", mem_req, mem_addr);
        end
        step();
        checks++;
        if (done !== 1'b1 || MDR_Data_Out !== 32'h1111_1111) begin
            errors++;
            $display("[TB] FAIL b2b_done1: got done=%b mdr=%h expected 1/11111111", done, MDR_Data_Out);
        end
        step();
        mem_rdata = 32'h2222_2222;
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || MDR_Data_Out !== 32'h1111_1111) begin
            errors++;
            $display("[TB] FAIL b2b_idle: got busy=%b req=%b mdr=%h expected 0/0/11111111",
                     busy, mem_req, MDR_Data_Out);
        end
        step();
        Read = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || MDR_Data_Out !== 32'h1111_1111) begin
            errors++;
            $display("[TB] FAIL b2b_req2: got req=%b mdr=%h expected 1/11111111", mem_req, MDR_Data_Out);
        end
        step();
        mem_ack = 1'b0;
        checks++;
        if (done !== 1'b1 || MDR_Data_Out !== 32'h2222_2222) begin
            errors++;
            $display("[TB] FAIL b2b_done2: got done=%b mdr=%h expected 1/22222222", done, MDR_Data_Out);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr = 1'b1; BusMuxOut = '0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
        mem_rdata = '0; mem_ack = 0;
        #1;
        test_reset();
        test_bus_loads();
        test_read_delayed();
        test_write_frozen();
        test_timeout();
        test_illegal();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
